ps2_device_tx: RTL and testbench
================================

// Module: ps2_device_tx
// PURPOSE
//  PS/2 device-side transmitter: emulates a keyboard/mouse sending bytes to a PS/2 host.
//  Generates the PS/2 clock itself and clocks out 11-bit frames from an internal byte FIFO.
//  Frame: start=0, D0..D7 LSB first, odd parity, stop=1.
//  Used to feed host-side PS/2 receivers (scancode injection, loopback of the keyboard path).
//  Backs off and retransmits when the host inhibits the bus.
// PARAMETERS
//  HALF_PERIOD  160  clk cycles per PS/2 clock half-period (160 @4MHz = 12.5kHz PS/2 clock)
//  IDLE_HOLD    200  consecutive clk cycles with synced clk&data high before a frame may start
//  FIFO_AW      3    FIFO address width; depth = 2**FIFO_AW = 8 bytes
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  din          in   8  byte to transmit
//  din_valid    in   1  write din into FIFO when din_ready=1
//  din_ready    out  1  FIFO not full
//  ps2clk_in    in   1  external PS/2 clock line level (async; 2-FF synced internally)
//  ps2data_in   in   1  external PS/2 data line level (async; 2-FF synced internally)
//  ps2clk_oe    out  1  1 = pull PS/2 clock low, 0 = release (open drain, pad makes 1'bZ)
//  ps2data_oe   out  1  1 = pull PS/2 data low, 0 = release
//  busy         out  1  1 while a frame is in progress (BIT_HI/BIT_LO/FINISH)
//  frame_sent   out  1  1-clk pulse: frame fully clocked out, byte popped from FIFO
//  host_rqs     out  1  1-clk pulse: host request-to-send seen (clk low, then data low while clk low)
//  fifo_level   out  4  number of bytes held, 0..8
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, frame_sent=0, host_rqs=0,
//   din_ready=1, fifo_level=0. Reset mid-frame releases both lines on the next clk edge; byte is lost.
//  FIFO: push when din_valid&din_ready; pop only on frame completion. Push and pop in the same
//   cycle are both performed (level unchanged). Push while full is ignored (din_ready=0).
//  States:
//   IDLE     : lines released. FIFO non-empty -> WAIT_IDLE, idle counter cleared.
//   WAIT_IDLE: count cycles with synced clk=1 & data=1; any low sample clears counter.
//              Counter reaches IDLE_HOLD -> BIT_HI, bit index=0, shift reg = {1,par,head,0}.
//   BIT_HI   : clock released; ps2data_oe = ~current bit from cycle 1 of phase.
//              After HALF_PERIOD cycles: synced clk=0 (host inhibit) -> INHIBIT, else -> BIT_LO.
//   BIT_LO   : ps2clk_oe=1 for HALF_PERIOD cycles (host samples on falling edge).
//              Then bit index<10 -> BIT_HI next bit; bit index=10 -> FINISH.
//   FINISH   : both released for HALF_PERIOD cycles; pop FIFO, pulse frame_sent, -> IDLE.
//   INHIBIT  : both released, byte NOT popped; on synced clk=1 -> WAIT_IDLE (full retransmit).
//  Inhibit detected in BIT_HI of bit 10 (stop) still aborts; after stop LO phase byte is accepted.
//  Parity: par = ~^byte (odd). Data line driven low only for 0-bits; 1-bits are released.
//  host_rqs: in IDLE/WAIT_IDLE, synced data falls while synced clk=0 -> 1-clk pulse; block stays
//   out of BIT_* until bus idle again. Host-to-device bytes are not received by this block.
//  Frame timing: 11*2*HALF_PERIOD + HALF_PERIOD clk cycles from BIT_HI entry to frame_sent
//   (3680 cycles at default). First data pull-low is IDLE_HOLD+1..+3 cycles after bus idle.
//  busy=1 exactly in BIT_HI, BIT_LO, FINISH. ps2clk_oe never asserts outside BIT_LO.
// TESTING
//  1 Push 8'h1C, bus idle -> 11 clk falls; host model decodes 0,00111000(LSB1st),par=0,1;
//    frame_sent once, fifo_level 1->0.
//  2 Push 8'hE0,8'hF0,8'h75 back-to-back -> three frames in order; no frame starts before IDLE_HOLD idle.
//  3 Push 9 bytes with bus held low -> din_ready=0 after 8th, 9th ignored, fifo_level=8.
//  4 Host pulls clk low during bit 5 BIT_HI -> lines released, no frame_sent, after release
//    same byte retransmitted from start bit; fifo_level unchanged until done.
//  5 Host holds clk low then pulls data low while idle -> host_rqs single pulse, no frame started.
//  6 Assert rst during bit 3 -> next edge oe outputs 0, fifo_level=0, busy=0, no frame_sent.

Source files
------------

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: buffers bytes in a small FIFO and clocks them out as
// 11-bit frames on a self-generated PS/2 clock, backing off whenever the host inhibits.
module ps2_device_tx #(
    parameter int HALF_PERIOD = 160,
    parameter int IDLE_HOLD   = 200,
    parameter int FIFO_AW     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               ps2clk_in,
    input  logic               ps2data_in,
    output logic               ps2clk_oe,
    output logic               ps2data_oe,
    output logic               busy,
    output logic               frame_sent,
    output logic               host_rqs,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CMAX  = (IDLE_HOLD > HALF_PERIOD) ? IDLE_HOLD : HALF_PERIOD;
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [CW-1:0]      HP_LAST   = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0]      IDLE_LAST = CW'(IDLE_HOLD - 1);
    localparam logic [FIFO_AW:0]   FULL      = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_BIT_HI, S_BIT_LO, S_FINISH, S_INHIBIT
    } state_t;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [3:0]          bit_idx, bit_nxt;
    logic [10:0]         shreg;
    logic                load, shift, pop, push;
    logic                clk_p0, clk_p1, data_p0, data_p1, data_p2;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wptr, rptr;

    // stage p0/p1: two-flop synchronisers; data_p2 holds the previous synced data level
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_p0  <= 1'b1;
            clk_p1  <= 1'b1;
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
            data_p2 <= 1'b1;
        end else begin
            clk_p0  <= ps2clk_in;
            clk_p1  <= clk_p0;
            data_p0 <= ps2data_in;
            data_p1 <= data_p0;
            data_p2 <= data_p1;
        end
    end

    assign din_ready = (fifo_level != FULL);
    assign push      = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            frame_sent <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            frame_sent <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Frame is {stop, parity, data, start}; bit 0 is always the bit currently on the wire.
    always_ff @(posedge clk) begin
        if (load)       shreg <= {1'b1, odd_par(mem[rptr]), mem[rptr], 1'b0};
        else if (shift) shreg <= {1'b1, shreg[10:1]};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        load      = 1'b0;
        shift     = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_level != '0) begin
                    state_nxt = S_WAIT_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_p1 && data_p1) begin
                    if (cnt == IDLE_LAST) begin
                        state_nxt = S_BIT_HI;
                        cnt_nxt   = '0;
                        bit_nxt   = '0;
                        load      = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            S_BIT_HI: begin
                if (cnt == HP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = clk_p1 ? S_BIT_LO : S_INHIBIT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BIT_LO: begin
                if (cnt == HP_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == 4'd10) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_BIT_HI;
                        shift     = 1'b1;
                        bit_nxt   = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_FINISH: begin
                if (cnt == HP_LAST) begin
                    cnt_nxt   = '0;
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_INHIBIT: begin
                if (clk_p1) begin
                    state_nxt = S_WAIT_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy       = (state == S_BIT_HI) || (state == S_BIT_LO) || (state == S_FINISH);
    assign ps2clk_oe  = (state == S_BIT_LO);
    assign ps2data_oe = ((state == S_BIT_HI) || (state == S_BIT_LO)) && !shreg[0];
    assign host_rqs   = ((state == S_IDLE) || (state == S_WAIT_IDLE)) &&
                        data_p2 && !data_p1 && !clk_p1;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: host-side line model decodes frames against a scoreboard of
// expected 11-bit frames; directed sequences cover FIFO full, inhibit, request-to-send and reset.
module tb_ps2_device_tx;
    localparam int HP = 20;
    localparam int IH = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, ps2clk_oe, ps2data_oe, busy, frame_sent, host_rqs;
    logic [3:0] fifo_level;
    logic       host_clk_low = 1'b0;
    logic       host_data_low = 1'b0;
    logic       bus_clk, bus_data;

    assign bus_clk  = !ps2clk_oe && !host_clk_low;
    assign bus_data = !ps2data_oe && !host_data_low;

    always #5 clk = ~clk;

    ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_HOLD(IH), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .ps2clk_in(bus_clk), .ps2data_in(bus_data), .ps2clk_oe(ps2clk_oe),
        .ps2data_oe(ps2data_oe), .busy(busy), .frame_sent(frame_sent),
        .host_rqs(host_rqs), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [7:0]  din;
        logic [10:0] frame;
    } vec_t;

    vec_t        vecs [7];
    logic [10:0] sb [$];
    int passed = 0, total = 0;
    int frames_cnt = 0, rqs_cnt = 0, busy_rises = 0, oe_bad = 0;
    int cyc = 0, t0 = 0, idle_run = 0;
    int f0, r0, b0;
    logic busy_q = 1'b0;
    logic acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b, input logic [10:0] f, output logic ok);
        din = b;
        din_valid = 1'b1;
        ok = din_ready;
        @(negedge clk);
        din_valid = 1'b0;
        if (ok) sb.push_back(f);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, frames_cnt >= target, 1);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", busy, 1);
    endtask

    // Line monitor: frame timing, idle-before-start, pulse counting.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_sent) begin
                frames_cnt++;
                chk("frame_time", cyc - t0, 23 * HP);
            end
            if (host_rqs) rqs_cnt++;
            if (busy && !busy_q) begin
                busy_rises++;
                t0 = cyc;
                chk("idle_before_start", idle_run >= IH, 1);
            end
            busy_q = busy;
            if (ps2clk_oe && !busy) oe_bad++;
            if (bus_clk && bus_data) idle_run++;
            else idle_run = 0;
        end
    end

    // Host receiver: samples data on each device-driven clock fall.
    initial begin
        logic [10:0] rx;
        logic [10:0] e;
        logic prev;
        int nb, quiet;
        rx = '0;
        prev = 1'b1;
        nb = 0;
        quiet = 0;
        forever begin
            @(negedge clk);
            if (host_clk_low) begin
                nb = 0;
                quiet = 0;
            end else if (prev && !bus_clk) begin
                rx[nb] = bus_data;
                nb++;
                quiet = 0;
                if (nb == 11) begin
                    nb = 0;
                    chk("rx_expected_pending", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rx_frame", rx, e);
                    end
                end
            end else begin
                quiet++;
                if (quiet > 4 * HP) nb = 0;
            end
            prev = bus_clk;
        end
    end

    initial begin
        vecs[0] = '{8'h1C, 11'b1_0_00011100_0};
        vecs[1] = '{8'hE0, 11'b1_0_11100000_0};
        vecs[2] = '{8'hF0, 11'b1_1_11110000_0};
        vecs[3] = '{8'h75, 11'b1_0_01110101_0};
        vecs[4] = '{8'h00, 11'b1_1_00000000_0};
        vecs[5] = '{8'hFF, 11'b1_1_11111111_0};
        vecs[6] = '{8'h01, 11'b1_0_00000001_0};

        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2clk_oe, 0);
        chk("rst_data_oe", ps2data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_sent", frame_sent, 0);
        chk("rst_host_rqs", host_rqs, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single byte 1C
        f0 = frames_cnt;
        push(vecs[0].din, vecs[0].frame, acc);
        chk("t1_level_after_push", fifo_level, 1);
        wait_frames(f0 + 1, 1500, "t1_frame_done");
        chk("t1_level_after_frame", fifo_level, 0);
        repeat (20) @(negedge clk);
        chk("t1_frame_count", frames_cnt - f0, 1);

        // back-to-back table bytes
        f0 = frames_cnt;
        for (int i = 1; i < 7; i++) begin
            push(vecs[i].din, vecs[i].frame, acc);
            chk("t2_push_accepted", acc, 1);
        end
        wait_frames(f0 + 6, 6 * 800, "t2_frames_done");
        chk("t2_level_end", fifo_level, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // FIFO fill with bus held low
        host_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            push(vecs[i % 7].din, vecs[i % 7].frame, acc);
            if (i == 8) chk("t3_ninth_ignored", acc, 0);
        end
        chk("t3_din_ready_full", din_ready, 0);
        chk("t3_level_full", fifo_level, 8);
        chk("t3_not_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("t3_level_after_rst", fifo_level, 0);
        chk("t3_ready_after_rst", din_ready, 1);
        host_clk_low = 1'b0;
        repeat (10) @(negedge clk);

        // host inhibit during bit 5
        f0 = frames_cnt;
        push(vecs[2].din, vecs[2].frame, acc);
        wait_busy(300);
        repeat (10 * HP + HP / 2) @(negedge clk);
        host_clk_low = 1'b1;
        repeat (HP + 5) @(negedge clk);
        chk("t4_busy_inhibit", busy, 0);
        chk("t4_clk_oe_inhibit", ps2clk_oe, 0);
        chk("t4_data_oe_inhibit", ps2data_oe, 0);
        chk("t4_level_held", fifo_level, 1);
        chk("t4_no_frame_sent", frames_cnt - f0, 0);
        repeat (50) @(negedge clk);
        host_clk_low = 1'b0;
        wait_frames(f0 + 1, 1500, "t4_retransmit_done");
        chk("t4_level_end", fifo_level, 0);
        chk("t4_sb_empty", sb.size(), 0);
        repeat (10) @(negedge clk);

        // host request-to-send while idle
        f0 = frames_cnt;
        r0 = rqs_cnt;
        b0 = busy_rises;
        host_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        host_data_low = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_rqs_pulse", rqs_cnt - r0, 1);
        chk("t5_not_busy", busy, 0);
        host_data_low = 1'b0;
        repeat (5) @(negedge clk);
        host_clk_low = 1'b0;
        repeat (IH + 20) @(negedge clk);
        chk("t5_rqs_single", rqs_cnt - r0, 1);
        chk("t5_no_start", busy_rises - b0, 0);
        chk("t5_no_frame", frames_cnt - f0, 0);

        // reset during bit 3
        f0 = frames_cnt;
        push(vecs[3].din, vecs[3].frame, acc);
        wait_busy(300);
        repeat (6 * HP + HP / 2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_clk_oe", ps2clk_oe, 0);
        chk("t6_data_oe", ps2data_oe, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_busy", busy, 0);
        chk("t6_frame_sent", frame_sent, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (30 * HP) @(negedge clk);
        chk("t6_no_frame", frames_cnt - f0, 0);
        chk("t6_idle_after", busy, 0);

        chk("clk_oe_outside_busy", oe_bad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
